// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the round-robin 2:1 mux select arbiter.
// Optional priority lock is enabled by defining MUX_ARB_LOCK_EN.
package mux_sel_arbiter_pkg;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  typedef enum logic {
    ARB_ST_IDLE = 1'b0,
    ARB_ST_HOLD = 1'b1
  } arb_state_e;

  // Round-robin update: the winner yields priority unless a lock pins it.
  function automatic logic next_prio(input logic prio, input logic winner, input logic lock);
    return lock ? prio : ~winner;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between two producers, the arbiter and the downstream consumer.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_sel_arbiter_if #(parameter int WIDTH = 8);

  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             select;
  logic             out_ready;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;
`endif

  modport master (
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, select
  );

  modport slave (
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, select
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; prio names the input that wins a tie.
module rr_pick2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_prio,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_any
);

  assign o_grant0 = i_valid0 & (~i_valid1 | ~i_prio);
  assign o_grant1 = i_valid1 & (~i_valid0 |  i_prio);
  assign o_any    = i_valid0 | i_valid1;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Fair, back-pressured 2:1 merge with a one-entry output register and registered mux select.
// Define MUX_ARB_LOCK_EN to add the lock input that pins priority on the current source.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int INIT_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_sel_arbiter_if.slave    bus
);

  localparam logic P_INIT_PRIO = (INIT_PRIO != 0);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic             r_prio;
  logic             w_prio_next;
  logic             r_select;
  logic [WIDTH-1:0] r_out_data;

  logic             w_out_valid;
  logic             w_slot_free;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_any;
  logic             w_accept;
  logic             w_lock;
  logic [WIDTH-1:0] w_win_data;

  rr_pick2 u_pick (
    .i_valid0 (bus.in0_valid),
    .i_valid1 (bus.in1_valid),
    .i_prio   (r_prio),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1),
    .o_any    (w_any)
  );

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  // Readies depend only on state, valids, prio and out_ready, never on each other.
  assign w_out_valid = (r_state == ARB_ST_HOLD);
  assign w_slot_free = (r_state == ARB_ST_IDLE) | (w_out_valid & bus.out_ready);
  assign w_accept    = w_slot_free & w_any;
  assign w_win_data  = w_grant1 ? bus.in1_data : bus.in0_data;

  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    if (w_accept) begin
      w_state_next = ARB_ST_HOLD;
      w_prio_next  = next_prio(r_prio, w_grant1, w_lock);
    end else if (w_out_valid & bus.out_ready) begin
      w_state_next = ARB_ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_ST_IDLE;
      r_prio     <= P_INIT_PRIO;
      r_select   <= SEL_IN0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_prio  <= w_prio_next;
      if (w_accept) begin
        r_select   <= w_grant1 ? SEL_IN1 : SEL_IN0;
        r_out_data <= w_win_data;
      end
    end
  end

  assign bus.in0_ready = w_slot_free & w_grant0;
  assign bus.in1_ready = w_slot_free & w_grant1;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.select    = r_select;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: expected words are queued at accept and compared while held.
// Define MUX_ARB_LOCK_EN to also exercise the priority lock.
module tb_mux_sel_arbiter;

  localparam int WIDTH     = 8;
  localparam int INIT_PRIO = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic       m_full;
  logic       m_prio;
  logic [8:0] exp_q[$];

  mux_sel_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_sel_arbiter #(.WIDTH(WIDTH), .INIT_PRIO(INIT_PRIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_full = 1'b0;
    m_prio = (INIT_PRIO != 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Reference model for one clock edge using the bench-driven inputs; no comparisons here.
  task automatic model_step(output logic e0, output logic e1);
    logic slot, win, lk;
    lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lk = bus.lock;
`endif
    e0 = 1'b0;
    e1 = 1'b0;
    slot = !m_full || bus.out_ready;
    if (bus.in0_valid && bus.in1_valid) win = m_prio;
    else win = bus.in1_valid;
    if (m_full && bus.out_ready && exp_q.size() > 0) begin
      $display("drain sel=%0d data=%h", exp_q[0][8], exp_q[0][7:0]);
      void'(exp_q.pop_front());
    end
    if (slot && (bus.in0_valid || bus.in1_valid)) begin
      if (win) e1 = 1'b1; else e0 = 1'b1;
      exp_q.push_back({win, win ? bus.in1_data : bus.in0_data});
      m_prio = lk ? m_prio : !win;
      m_full = 1'b1;
    end else if (bus.out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    n_checks++;
    if (bus.select !== 1'b0) begin n_errors++; $display("FAIL reset_select got=%0b exp=0", bus.select); end
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
      n_errors++; $display("FAIL reset_readys got=%b exp=00", {bus.in0_ready, bus.in1_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_source();
    logic e0, e1;
    int acc0 = 0;
    apply_reset();
    bus.in0_data = 8'h11;
    bus.in1_data = 8'hF0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in0_valid = (c < 3);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== m_full) begin n_errors++; $display("FAIL single_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_full); end
      if (m_full) begin
        n_checks++;
        if ({bus.select, bus.out_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL single_word c=%0d got=%h exp=%h", c, {bus.select, bus.out_data}, exp_q[0]);
        end
      end
      model_step(e0, e1);
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {e0, e1}) begin
        n_errors++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, {bus.in0_ready, bus.in1_ready}, {e0, e1});
      end
      if (e0) acc0++;
      @(posedge clk);
      #1;
      if (e0) bus.in0_data = bus.in0_data + 8'h11;
    end
    n_checks++;
    if (acc0 != 3) begin n_errors++; $display("FAIL single_count got=%0d exp=3", acc0); end
  endtask

  task automatic test_alternation();
    logic e0, e1;
    apply_reset();
    bus.in0_data = 8'h01;
    bus.in1_data = 8'h81;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== m_full) begin n_errors++; $display("FAIL alt_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_full); end
      if (m_full) begin
        n_checks++;
        if ({bus.select, bus.out_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL alt_word c=%0d got=%h exp=%h", c, {bus.select, bus.out_data}, exp_q[0]);
        end
      end
      model_step(e0, e1);
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {e0, e1}) begin
        n_errors++; $display("FAIL alt_ready c=%0d got=%b exp=%b", c, {bus.in0_ready, bus.in1_ready}, {e0, e1});
      end
      @(posedge clk);
      #1;
      if (e0) bus.in0_data = bus.in0_data + 8'h11;
      if (e1) bus.in1_data = bus.in1_data + 8'h11;
    end
  endtask

  task automatic test_stall();
    logic e0, e1;
    apply_reset();
    bus.in0_data = 8'h5C;
    bus.in1_data = 8'h70;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = (c >= 4);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== m_full) begin n_errors++; $display("FAIL stall_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_full); end
      if (m_full) begin
        n_checks++;
        if ({bus.select, bus.out_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL stall_word c=%0d got=%h exp=%h", c, {bus.select, bus.out_data}, exp_q[0]);
        end
      end
      model_step(e0, e1);
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {e0, e1}) begin
        n_errors++; $display("FAIL stall_ready c=%0d got=%b exp=%b", c, {bus.in0_ready, bus.in1_ready}, {e0, e1});
      end
      @(posedge clk);
      #1;
      if (e0) bus.in0_data = bus.in0_data + 8'h11;
      if (e1) bus.in1_data = bus.in1_data + 8'h11;
    end
  endtask

  task automatic test_prio_flip();
    logic e0, e1;
    apply_reset();
    bus.in0_data = 8'h30;
    bus.in1_data = 8'h90;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in1_valid = 1'b1;
      bus.in0_valid = (c >= 1) && (c < 5);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== m_full) begin n_errors++; $display("FAIL flip_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_full); end
      if (m_full) begin
        n_checks++;
        if ({bus.select, bus.out_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL flip_word c=%0d got=%h exp=%h", c, {bus.select, bus.out_data}, exp_q[0]);
        end
      end
      model_step(e0, e1);
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {e0, e1}) begin
        n_errors++; $display("FAIL flip_ready c=%0d got=%b exp=%b", c, {bus.in0_ready, bus.in1_ready}, {e0, e1});
      end
      @(posedge clk);
      #1;
      if (e0) bus.in0_data = bus.in0_data + 8'h11;
      if (e1) bus.in1_data = bus.in1_data + 8'h11;
    end
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    logic e0, e1;
    apply_reset();
    bus.in0_data = 8'h0A;
    bus.in1_data = 8'hA0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.in0_valid = 1'b1;
      bus.in1_valid = (c >= 1);
      bus.lock = (c >= 1) && (c < 5);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== m_full) begin n_errors++; $display("FAIL lock_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_full); end
      if (m_full) begin
        n_checks++;
        if ({bus.select, bus.out_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL lock_word c=%0d got=%h exp=%h", c, {bus.select, bus.out_data}, exp_q[0]);
        end
      end
      model_step(e0, e1);
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {e0, e1}) begin
        n_errors++; $display("FAIL lock_ready c=%0d got=%b exp=%b", c, {bus.in0_ready, bus.in1_ready}, {e0, e1});
      end
      @(posedge clk);
      #1;
      if (e0) bus.in0_data = bus.in0_data + 8'h11;
      if (e1) bus.in1_data = bus.in1_data + 8'h11;
    end
    bus.lock = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_hold();
    apply_reset();
    bus.in1_data = 8'hA5;
    bus.in1_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in1_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.select, bus.out_data} !== {2'b11, 8'hA5}) begin
      n_errors++; $display("FAIL midrst_held got=%b_%b_%h exp=1_1_a5", bus.out_valid, bus.select, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got=%0b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.select !== 1'b0) begin n_errors++; $display("FAIL midrst_select got=%0b exp=0", bus.select); end
    n_checks++;
    if (bus.out_data !== 8'h00) begin n_errors++; $display("FAIL midrst_data got=%h exp=00", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in0_data = 8'h44;
    bus.in1_data = 8'h55;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== {INIT_PRIO == 0, INIT_PRIO != 0}) begin
      n_errors++; $display("FAIL midrst_tie got=%b exp=%b", {bus.in0_ready, bus.in1_ready}, {INIT_PRIO == 0, INIT_PRIO != 0});
    end
    @(posedge clk);
    #1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  initial begin
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
    bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    m_full = 1'b0;
    m_prio = (INIT_PRIO != 0);
    test_reset();
    test_single_source();
    test_alternation();
    test_stall();
    test_prio_flip();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
